fs_serial: RTL and testbench

FS_SERIAL -- requirements
Module: fs_serial

---
 rtl/fs_serial.sv | 102 ++++++++++
 tb/tb_fs_serial.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fs_serial.sv
// Bit-serial unsigned subtractor: d = a - b mod 2^WIDTH, one bit per clock, LSB first.
// Optional signed-overflow flag on port ovf when SUB_OVF_EN is defined.
module fs_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             diff_c;
  logic             bout_c;

`ifdef SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // One-bit full subtractor on the current LSBs
  assign diff_c = sa[0] ^ sb[0] ^ borrow;
  assign bout_c = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);

  // Control FSM, operand shifters and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bo     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= bout_c;
          // New difference bit enters at the top; after WIDTH-1 steps bit 0 sits at res[0]
          res    <= (WIDTH-1)'({diff_c, res} >> 1);
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            d     <= {diff_c, res};
            bo    <= bout_c;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef SUB_OVF_EN
            ovf   <= (a_msb != b_msb) & (diff_c != a_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fs_serial.sv
// Self-checking bench for fs_serial: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results.
module tb_fs_serial;

  localparam int unsigned W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] d;
  logic         bo;
  logic         busy;
  logic         done;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  fs_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .d     (d),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result computed arithmetically, delivered WIDTH cycles after acceptance
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_d    = '0;
  logic         m_bo   = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] p_d    = '0;
  logic         p_bo   = 1'b0;
  logic         p_ovf  = 1'b0;
  int           remaining = 0;

  function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sd;
    sd = int'($signed(x)) - int'($signed(y));
    return (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_d       <= '0;
      m_bo      <= 1'b0;
      m_ovf     <= 1'b0;
      remaining <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (remaining == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_d    <= p_d;
          m_bo   <= p_bo;
          m_ovf  <= p_ovf;
        end
        remaining <= remaining - 1;
      end else if (start) begin
        m_busy    <= 1'b1;
        remaining <= W;
        p_d       <= W'(a - b);
        p_bo      <= (a < b);
        p_ovf     <= signed_ovf(a, b);
      end
    end
  end

  // Cycle-by-cycle comparison, sampled away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("d",    32'(d),    32'(m_d));
      check("bo",   32'(bo),   32'(m_bo));
`ifdef SUB_OVF_EN
      check("ovf",  32'(ovf),  32'(m_ovf));
`endif
      if (done) done_cnt++;
    end
  end

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < 4 * W) begin
      @(negedge clk);
      n++;
      if (done) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", 4 * W);
    end
  endtask

  task automatic run(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input logic [W-1:0] ed, input logic ebo);
    int lat;
    start_op(av, bv);
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'(W));
    check({name, "_d"},       32'(d),   32'(ed));
    check({name, "_bo"},      32'(bo),  32'(ebo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int d0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d",    32'(d),    32'h0);
    check("rst_bo",   32'(bo),   32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
`ifdef SUB_OVF_EN
    check("rst_ovf",  32'(ovf),  32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("sub_5_3",   8'h05, 8'h03, 8'h02, 1'b0);
    run("sub_3_5",   8'h03, 8'h05, 8'hFE, 1'b1);
    run("sub_0_1",   8'h00, 8'h01, 8'hFF, 1'b1);
    run("sub_a5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0);
    run("sub_0_ff",  8'h00, 8'hFF, 8'h01, 1'b1);

    // Result holds while idle
    repeat (5) @(posedge clk);
    #1;
    check("hold_d",  32'(d),  32'h01);
    check("hold_bo", 32'(bo), 32'h1);

    // Start held high while busy, operands change mid-operation
    d0 = done_cnt;
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    a = 8'hFF;
    b = 8'hFF;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    repeat (2 * W) @(posedge clk);
    #1;
    check("held_start_dones", 32'(done_cnt - d0), 32'd1);
    check("held_start_d",     32'(d),             32'h0F);
    check("held_start_bo",    32'(bo),            32'h0);

    // Reset mid-operation aborts without a done pulse
    d0 = done_cnt;
    start_op(8'h20, 8'h01);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_d",    32'(d),    32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * W) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run("after_rst", 8'h09, 8'h04, 8'h05, 1'b0);

    // Back-to-back: second start asserted during the done cycle
    start_op(8'h40, 8'h01);
    wait_done(lat);
    check("b2b1_latency", 32'(lat), 32'(W));
    check("b2b1_d",       32'(d),   32'h3F);
    check("b2b1_bo",      32'(bo),  32'h0);
    start_op(8'h01, 8'h02);
    check("b2b_hold_d",   32'(d),   32'h3F);
    wait_done(lat);
    check("b2b2_latency", 32'(lat), 32'(W));
    check("b2b2_d",       32'(d),   32'hFF);
    check("b2b2_bo",      32'(bo),  32'h1);
    @(posedge clk);
    #1;

`ifdef SUB_OVF_EN
    run("ovf_80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
    check("ovf_80_01_ovf", 32'(ovf), 32'h1);
    run("ovf_7f_01", 8'h7F, 8'h01, 8'h7E, 1'b0);
    check("ovf_7f_01_ovf", 32'(ovf), 32'h0);
    run("ovf_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1);
    check("ovf_7f_ff_ovf", 32'(ovf), 32'h1);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
